uart_tx_feeder: RTL and testbench

//  Byte buffer and launch controller sitting directly upstream of the UART transmitter.

---
 rtl/uart_tx_feeder.sv | 130 +++++++++++++
 tb/tb_uart_tx_feeder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_feeder.sv
// Byte FIFO feeding a UART transmitter: launches one byte per frame as a
// single-cycle Data_Valid pulse, paced by the transmitter's Busy handshake.
module uart_tx_feeder #(
    parameter int DATA_WIDTH   = 8,
    parameter int DEPTH        = 8,
    parameter int ADDR_WIDTH   = 3,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   fifo_count,
    output logic                  wr_overflow,
    input  logic                  tx_busy,
    output logic                  tx_data_valid,
    output logic [DATA_WIDTH-1:0] tx_p_data,
    output logic                  launch_err
);
    localparam int TW = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [ADDR_WIDTH:0] DEPTH_C   = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [TW-1:0]       TIMEOUT_C = TW'(BUSY_TIMEOUT);

    typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]     count_q, count_d;
    logic [TW-1:0]           timer_q, timer_d;
    logic                    wr_overflow_q, wr_overflow_d;
    logic                    tx_data_valid_q, tx_data_valid_d;
    logic [DATA_WIDTH-1:0]   tx_p_data_q, tx_p_data_d;
    logic                    launch_err_q, launch_err_d;
    logic                    push, pop;

    assign full          = (count_q == DEPTH_C);
    assign empty         = (count_q == '0);
    assign fifo_count    = count_q;
    assign wr_overflow   = wr_overflow_q;
    assign tx_data_valid = tx_data_valid_q;
    assign tx_p_data     = tx_p_data_q;
    assign launch_err    = launch_err_q;

    // A write while full is dropped even if a pop happens on the same edge.
    assign push = wr_en && !full;

    always_comb begin
        state_d         = state_q;
        timer_d         = timer_q;
        tx_data_valid_d = 1'b0;
        tx_p_data_d     = tx_p_data_q;
        launch_err_d    = 1'b0;
        pop             = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty && !tx_busy) begin
                    pop             = 1'b1;
                    tx_p_data_d     = mem_q[rd_ptr_q];
                    tx_data_valid_d = 1'b1;
                    timer_d         = '0;
                    state_d         = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else begin
                    // Transmitter never acknowledged: give up, the byte is gone.
                    timer_d = timer_q + TW'(1);
                    if (timer_d == TIMEOUT_C) begin
                        state_d      = IDLE;
                        launch_err_d = 1'b1;
                    end
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d      = push ? wr_ptr_q + ADDR_WIDTH'(1) : wr_ptr_q;
        rd_ptr_d      = pop  ? rd_ptr_q + ADDR_WIDTH'(1) : rd_ptr_q;
        wr_overflow_d = wr_en && full;
        count_d       = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (ADDR_WIDTH + 1)'(1);
            2'b01:   count_d = count_q - (ADDR_WIDTH + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q         <= IDLE;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            timer_q         <= '0;
            wr_overflow_q   <= 1'b0;
            tx_data_valid_q <= 1'b0;
            tx_p_data_q     <= '0;
            launch_err_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            timer_q         <= timer_d;
            wr_overflow_q   <= wr_overflow_d;
            tx_data_valid_q <= tx_data_valid_d;
            tx_p_data_q     <= tx_p_data_d;
            launch_err_q    <= launch_err_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: random and directed writes, a behavioural transmitter,
// and a scoreboard monitor comparing every launched byte and pulse against a queue model.
module tb_uart_tx_feeder;
    localparam int DEPTH = 8;
    localparam int NCYC  = 16384;
    localparam int M_NORMAL = 0, M_FORCE = 1, M_STUCK = 2;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       full, empty, wr_overflow, tx_data_valid, launch_err;
    logic [3:0] fifo_count;
    logic       tx_busy = 1'b0;
    logic [7:0] tx_p_data;

    uart_tx_feeder #(.DATA_WIDTH(8), .DEPTH(8), .ADDR_WIDTH(3), .BUSY_TIMEOUT(4)) dut (
        .CLK(CLK), .RST(RST), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .empty(empty), .fifo_count(fifo_count), .wr_overflow(wr_overflow),
        .tx_busy(tx_busy), .tx_data_valid(tx_data_valid), .tx_p_data(tx_p_data),
        .launch_err(launch_err)
    );

    always #5 CLK = ~CLK;

    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    int         occ = 0;
    int         mode = M_NORMAL;
    int         frame_len = 11;
    int         busy_cnt = 0;
    bit         rand_frames = 1'b0;
    bit         in_reset = 1'b1;
    bit         prev_valid = 1'b0;
    logic [7:0] last_data = 8'h00;
    logic [7:0] exp_q[$];
    bit         exp_ovf[NCYC];
    bit         exp_err[NCYC];
    bit         exp_launch[NCYC];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor + transmitter model, evaluated once per cycle away from the active edge.
    always @(negedge CLK) begin
        logic [7:0] exp_d;
        cyc++;
        if (!in_reset) begin
            if (exp_launch[cyc]) chk("launch_timing", int'(tx_data_valid), 1);
            if (exp_err[cyc] || launch_err) chk("launch_err", int'(launch_err), int'(exp_err[cyc]));
            if (exp_ovf[cyc] || wr_overflow) chk("wr_overflow", int'(wr_overflow), int'(exp_ovf[cyc]));
            if (tx_data_valid) begin
                chk("valid_one_cycle", int'(prev_valid), 0);
                chk("launch_while_busy", int'(tx_busy), 0);
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_launch: got byte 0x%0h, expected no launch (cycle %0d)",
                             tx_p_data, cyc);
                end else begin
                    exp_d = exp_q.pop_front();
                    chk("tx_p_data", int'(tx_p_data), int'(exp_d));
                    last_data = exp_d;
                    occ--;
                end
                if (mode == M_STUCK) begin
                    if (cyc + 4 < NCYC) exp_err[cyc + 4] = 1'b1;
                end else if (mode == M_NORMAL) begin
                    if (rand_frames) frame_len = $urandom_range(1, 12);
                    tx_busy  = 1'b1;
                    busy_cnt = frame_len;
                end
            end else if (tx_busy && mode == M_NORMAL) begin
                chk("p_data_stable", int'(tx_p_data), int'(last_data));
            end
            if (mode == M_NORMAL && tx_busy && !tx_data_valid) begin
                busy_cnt--;
                if (busy_cnt == 0) begin
                    tx_busy = 1'b0;
                    if (occ > 0 && cyc + 2 < NCYC) exp_launch[cyc + 2] = 1'b1;
                end
            end
            if (mode == M_STUCK && exp_err[cyc] && occ > 0 && cyc + 1 < NCYC) begin
                exp_launch[cyc + 1] = 1'b1;
            end
        end
        prev_valid = tx_data_valid;
    end

    task automatic step(input bit do_wr, input logic [7:0] d);
        @(negedge CLK);
        #1;
        chk("fifo_count", int'(fifo_count), occ);
        chk("full", int'(full), int'(occ == DEPTH));
        chk("empty", int'(empty), int'(occ == 0));
        wr_en   = do_wr;
        wr_data = d;
        if (do_wr) begin
            if (occ == DEPTH) begin
                if (cyc + 1 < NCYC) exp_ovf[cyc + 1] = 1'b1;
            end else begin
                exp_q.push_back(d);
                occ++;
            end
        end
    endtask

    task automatic drain(input int extra);
        int n = 0;
        while ((exp_q.size() != 0 || tx_busy || occ != 0) && n < 600) begin
            step(1'b0, 8'h00);
            n++;
        end
        chk("drain_done", int'(n < 600), 1);
        repeat (extra) step(1'b0, 8'h00);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        #1;
        in_reset = 1'b1;
        RST      = 1'b0;
        wr_en    = 1'b0;
        #1;
        chk("rst_full", int'(full), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_count", int'(fifo_count), 0);
        chk("rst_overflow", int'(wr_overflow), 0);
        chk("rst_valid", int'(tx_data_valid), 0);
        chk("rst_p_data", int'(tx_p_data), 0);
        chk("rst_launch_err", int'(launch_err), 0);
        tx_busy  = 1'b0;
        busy_cnt = 0;
        mode     = M_NORMAL;
        exp_q.delete();
        occ = 0;
        for (int i = 0; i < NCYC; i++) begin
            exp_ovf[i]    = 1'b0;
            exp_err[i]    = 1'b0;
            exp_launch[i] = 1'b0;
        end
        repeat (2) @(negedge CLK);
        #1;
        RST      = 1'b1;
        in_reset = 1'b0;
    endtask

    initial begin
        int n;
        do_reset();

        // Single byte: launch expected two samples after the write is driven.
        frame_len = 11;
        step(1'b1, 8'hA5);
        if (cyc + 2 < NCYC) exp_launch[cyc + 2] = 1'b1;
        drain(3);

        // Burst of 8 consecutive writes.
        for (int i = 1; i <= 8; i++) step(1'b1, 8'(i));
        drain(3);

        // Overflow: transmitter busy with a foreign frame while the FIFO fills.
        mode    = M_FORCE;
        tx_busy = 1'b1;
        for (int i = 0; i < 8; i++) step(1'b1, 8'h10 + 8'(i));
        step(1'b1, 8'h5A);
        repeat (3) step(1'b0, 8'h00);
        mode    = M_NORMAL;
        frame_len = 3;
        tx_busy = 1'b0;
        if (cyc + 1 < NCYC) exp_launch[cyc + 1] = 1'b1;
        drain(3);

        // Random traffic with random frame lengths: push/pop overlap and pointer wrap.
        rand_frames = 1'b1;
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) < 40), 8'($urandom));
        end
        drain(3);
        rand_frames = 1'b0;

        // Busy-one-cycle frames so push and pop coincide around count=1.
        frame_len = 1;
        for (int i = 0; i < 20; i++) step(1'b1, 8'($urandom));
        drain(3);

        // Timeout: transmitter never raises Busy.
        mode = M_STUCK;
        step(1'b1, 8'h3C);
        step(1'b1, 8'h77);
        drain(8);
        mode = M_NORMAL;

        // Reset while a frame is in flight and three bytes are still queued.
        frame_len = 30;
        for (int i = 0; i < 4; i++) step(1'b1, 8'hC0 + 8'(i));
        n = 0;
        while (!tx_busy && n < 50) begin
            step(1'b0, 8'h00);
            n++;
        end
        chk("busy_before_reset", int'(tx_busy), 1);
        repeat (2) step(1'b0, 8'h00);
        chk("queued_before_reset", occ, 3);
        do_reset();

        // Recovery after reset.
        frame_len = 5;
        step(1'b1, 8'h42);
        if (cyc + 2 < NCYC) exp_launch[cyc + 2] = 1'b1;
        drain(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
